// File: rtl/shared_fifo_bank_pkg.sv
// Shared definitions for the linked-list FIFO bank: derived widths and the enqueue source type.
package shared_fifo_bank_pkg;

  typedef enum logic [1:0] {
    ENQ_NONE,
    ENQ_PUSH,
    ENQ_REINSERT
  } enq_src_e;

  function automatic int idx_width(input int num_flows);
    return $clog2(num_flows + 1);
  endfunction

  function automatic int ptr_width(input int total_depth);
    return (total_depth > 1) ? $clog2(total_depth) : 1;
  endfunction

  function automatic int cnt_width(input int total_depth);
    return $clog2(total_depth + 1);
  endfunction

  // Width needed to index the per-flow arrays, so flow ids can be sliced without width warnings.
  function automatic int sel_width(input int num_flows);
    return (num_flows > 1) ? $clog2(num_flows) : 1;
  endfunction

endpackage

// File: rtl/shared_fifo_free_list.sv
// Entry allocator for the shared pool: a bump pointer hands out never-used entries,
// after which released entries are recycled through a singly linked free list.
module shared_fifo_free_list
  import shared_fifo_bank_pkg::*;
#(
  parameter int TOTAL_DEPTH = 64,
  localparam int PTR_WIDTH = ptr_width(TOTAL_DEPTH),
  localparam int CNT_WIDTH = cnt_width(TOTAL_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_req,
  output logic [PTR_WIDTH-1:0] alloc_ptr,
  input  logic                 release_valid,
  input  logic [PTR_WIDTH-1:0] release_ptr,
  output logic [CNT_WIDTH-1:0] free_count
);

  logic [CNT_WIDTH-1:0] fresh;
  logic [CNT_WIDTH-1:0] fl_count;
  logic [PTR_WIDTH-1:0] fl_head;
  logic [PTR_WIDTH-1:0] fl_next [TOTAL_DEPTH];
  logic                 from_fresh;
  logic                 list_alloc;

  assign from_fresh = (fresh != CNT_WIDTH'(TOTAL_DEPTH));
  assign list_alloc = alloc_req && !from_fresh;
  assign alloc_ptr  = from_fresh ? fresh[PTR_WIDTH-1:0] : fl_head;
  assign free_count = CNT_WIDTH'(TOTAL_DEPTH) - fresh + fl_count;

  // A simultaneous release and free-list allocation swaps the head without changing the list length.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fresh    <= '0;
      fl_head  <= '0;
      fl_count <= '0;
    end else begin
      if (alloc_req && from_fresh) fresh <= fresh + CNT_WIDTH'(1);
      if (release_valid && list_alloc) begin
        fl_head <= release_ptr;
      end else if (release_valid) begin
        fl_head  <= release_ptr;
        fl_count <= fl_count + CNT_WIDTH'(1);
      end else if (list_alloc) begin
        fl_head  <= fl_next[fl_head];
        fl_count <= fl_count - CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (release_valid) fl_next[release_ptr] <= list_alloc ? fl_next[fl_head] : fl_head;
  end

endmodule

// File: rtl/shared_fifo_bank.sv
// Per-flow FIFOs built as linked lists in one shared entry pool, with push, pop and
// same-flow reinsert, occupancy reporting and a sticky overflow flag for dropped reinserts.
module shared_fifo_bank
  import shared_fifo_bank_pkg::*;
#(
  parameter int NUM_FLOWS    = 16,
  parameter int TOTAL_DEPTH  = 64,
  parameter int MAX_PER_FLOW = 64,
  parameter int DATA_WIDTH   = 8,
  localparam int IDX_WIDTH = idx_width(NUM_FLOWS),
  localparam int PTR_WIDTH = ptr_width(TOTAL_DEPTH),
  localparam int CNT_WIDTH = cnt_width(TOTAL_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i__push_valid,
  input  logic [IDX_WIDTH-1:0]  i__push_flow_id,
  input  logic [DATA_WIDTH-1:0] i__push_data,
  output logic                  o__push_ready,
  input  logic                  i__reinsert_valid,
  input  logic [DATA_WIDTH-1:0] i__reinsert_data,
  input  logic [IDX_WIDTH-1:0]  i__pop_flow_id,
  input  logic                  i__pop,
  output logic                  o__pop_valid,
  output logic [DATA_WIDTH-1:0] o__pop_data,
  output logic [CNT_WIDTH-1:0]  o__pop_flow_count,
  output logic [CNT_WIDTH-1:0]  o__free_count,
  output logic                  o__overflow
);

  localparam int SEL_WIDTH = sel_width(NUM_FLOWS);

  logic [DATA_WIDTH-1:0] data     [TOTAL_DEPTH];
  logic [PTR_WIDTH-1:0]  next_ptr [TOTAL_DEPTH];
  logic [PTR_WIDTH-1:0]  head     [NUM_FLOWS];
  logic [PTR_WIDTH-1:0]  tail     [NUM_FLOWS];
  logic [CNT_WIDTH-1:0]  count    [NUM_FLOWS];
  logic                  overflow_q;

  logic [SEL_WIDTH-1:0]  pop_sel, push_sel, enq_sel;
  logic                  pop_in_range, push_in_range;
  logic                  do_pop, do_push, reinsert_ok, reinsert_drop, reuse;
  enq_src_e              enq_src;
  logic                  enq_valid, link_tail;
  logic [DATA_WIDTH-1:0] enq_data;
  logic [CNT_WIDTH-1:0]  enq_count;
  logic [PTR_WIDTH-1:0]  new_ptr, alloc_ptr;
  logic [CNT_WIDTH-1:0]  free_count;
  logic [NUM_FLOWS-1:0]  pop_hit, enq_hit;

  assign pop_sel       = i__pop_flow_id[SEL_WIDTH-1:0];
  assign push_sel      = i__push_flow_id[SEL_WIDTH-1:0];
  assign pop_in_range  = (i__pop_flow_id < IDX_WIDTH'(NUM_FLOWS));
  assign push_in_range = (i__push_flow_id < IDX_WIDTH'(NUM_FLOWS));

  assign o__pop_valid      = pop_in_range && (count[pop_sel] != '0);
  assign o__pop_data       = o__pop_valid ? data[head[pop_sel]] : '0;
  assign o__pop_flow_count = pop_in_range ? count[pop_sel] : '0;
  assign o__free_count     = free_count;
  assign o__overflow       = overflow_q;

  // Readiness deliberately ignores an entry freed by a same-cycle pop.
  assign o__push_ready = !i__reinsert_valid && push_in_range &&
                         (count[push_sel] < CNT_WIDTH'(MAX_PER_FLOW)) && (free_count != '0);

  assign do_pop        = i__pop && o__pop_valid;
  assign do_push       = i__push_valid && o__push_ready;
  assign reinsert_ok   = i__reinsert_valid && pop_in_range && ((free_count != '0) || do_pop);
  assign reinsert_drop = i__reinsert_valid && !reinsert_ok;
  assign reuse         = reinsert_ok && do_pop;

  // Select the single enqueue of the cycle and work out which pool entry it lands in.
  always_comb begin
    enq_src  = ENQ_NONE;
    enq_sel  = push_sel;
    enq_data = i__push_data;
    if (reinsert_ok) begin
      enq_src  = ENQ_REINSERT;
      enq_sel  = pop_sel;
      enq_data = i__reinsert_data;
    end else if (do_push) begin
      enq_src = ENQ_PUSH;
    end
    enq_valid = (enq_src != ENQ_NONE);
    enq_count = count[enq_sel];
    new_ptr   = reuse ? head[pop_sel] : alloc_ptr;
    link_tail = enq_valid && ((do_pop && pop_sel == enq_sel) ? (enq_count > CNT_WIDTH'(1))
                                                              : (enq_count != '0));
    for (int f = 0; f < NUM_FLOWS; f++) begin
      pop_hit[f] = do_pop && (pop_sel == SEL_WIDTH'(f));
      enq_hit[f] = enq_valid && (enq_sel == SEL_WIDTH'(f));
    end
  end

  shared_fifo_free_list #(
    .TOTAL_DEPTH(TOTAL_DEPTH)
  ) u_free_list (
    .clk          (clk),
    .reset        (reset),
    .alloc_req    (enq_valid && !reuse),
    .alloc_ptr    (alloc_ptr),
    .release_valid(do_pop && !reuse),
    .release_ptr  (head[pop_sel]),
    .free_count   (free_count)
  );

  // Per-flow list bookkeeping; a flow that pops and enqueues together keeps its count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int f = 0; f < NUM_FLOWS; f++) begin
        head[f]  <= '0;
        tail[f]  <= '0;
        count[f] <= '0;
      end
      overflow_q <= 1'b0;
    end else begin
      if (reinsert_drop) overflow_q <= 1'b1;
      for (int f = 0; f < NUM_FLOWS; f++) begin
        if (pop_hit[f] && enq_hit[f]) begin
          head[f] <= (count[f] == CNT_WIDTH'(1)) ? new_ptr : next_ptr[head[f]];
          tail[f] <= new_ptr;
        end else if (pop_hit[f]) begin
          head[f]  <= next_ptr[head[f]];
          count[f] <= count[f] - CNT_WIDTH'(1);
        end else if (enq_hit[f]) begin
          if (count[f] == '0) head[f] <= new_ptr;
          tail[f]  <= new_ptr;
          count[f] <= count[f] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Pool storage needs no reset: an entry is always written before any flow can expose it.
  always_ff @(posedge clk) begin
    if (enq_valid) begin
      data[new_ptr] <= enq_data;
      if (link_tail) next_ptr[tail[enq_sel]] <= new_ptr;
    end
  end

endmodule

// File: tb/tb_shared_fifo_bank.sv
// Self-checking bench for shared_fifo_bank: directed scenarios plus randomized traffic,
// all compared against per-flow queues that model the bank's contract directly.
module tb_shared_fifo_bank;

  localparam int NF  = 16;
  localparam int TD  = 64;
  localparam int MPF = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       push_valid;
  logic [4:0] push_flow_id;
  logic [7:0] push_data;
  logic       push_ready;
  logic       reinsert_valid;
  logic [7:0] reinsert_data;
  logic [4:0] pop_flow_id;
  logic       pop;
  logic       pop_valid;
  logic [7:0] pop_data;
  logic [6:0] pop_flow_count;
  logic [6:0] free_count;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq [NF][$];
  bit         m_ovf;

  always #5 clk = ~clk;

  shared_fifo_bank #(
    .NUM_FLOWS(NF), .TOTAL_DEPTH(TD), .MAX_PER_FLOW(MPF), .DATA_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset),
    .i__push_valid(push_valid), .i__push_flow_id(push_flow_id), .i__push_data(push_data),
    .o__push_ready(push_ready),
    .i__reinsert_valid(reinsert_valid), .i__reinsert_data(reinsert_data),
    .i__pop_flow_id(pop_flow_id), .i__pop(pop),
    .o__pop_valid(pop_valid), .o__pop_data(pop_data), .o__pop_flow_count(pop_flow_count),
    .o__free_count(free_count), .o__overflow(overflow)
  );

  // Reference model: one queue per flow, pool occupancy is the sum of queue sizes.
  function automatic int m_count(input logic [4:0] id);
    int k = int'(id);
    return (k < NF) ? mq[k].size() : 0;
  endfunction

  function automatic int m_total();
    int s = 0;
    for (int k = 0; k < NF; k++) s += mq[k].size();
    return s;
  endfunction

  function automatic logic [7:0] m_head(input logic [4:0] id);
    int k = int'(id);
    if (m_count(id) == 0) return 8'h00;
    return mq[k][0];
  endfunction

  function automatic bit m_ready();
    return !reinsert_valid && (int'(push_flow_id) < NF) &&
           (m_count(push_flow_id) < MPF) && (m_total() < TD);
  endfunction

  task automatic model_step();
    int  pk    = int'(pop_flow_id);
    int  qk    = int'(push_flow_id);
    bit  dopop = pop && (m_count(pop_flow_id) != 0);
    bit  rdy   = m_ready();
    bit  rok   = reinsert_valid && (pk < NF) && ((m_total() < TD) || dopop);
    if (reinsert_valid && !rok) m_ovf = 1'b1;
    if (dopop) void'(mq[pk].pop_front());
    if (rok) mq[pk].push_back(reinsert_data);
    else if (push_valid && rdy) mq[qk].push_back(push_data);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NF; k++) mq[k].delete();
    m_ovf = 1'b0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push_valid     = 1'b0;
    push_flow_id   = '0;
    push_data      = '0;
    reinsert_valid = 1'b0;
    reinsert_data  = '0;
    pop_flow_id    = '0;
    pop            = 1'b0;
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    total++; if (free_count !== 7'd64) begin bad++; $display("[TB] FAIL rst_free: got %0d expected 64", free_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL rst_ovf: got %b expected 0", overflow); end
    reset = 1'b1;
    model_reset();
    push_flow_id = 5'd3;
    pop_flow_id  = 5'd3;
    #1;
    total++; if (pop_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid: got %b expected 0", pop_valid); end
    total++; if (pop_data !== 8'h00) begin bad++; $display("[TB] FAIL rst_data: got %h expected 00", pop_data); end
    total++; if (pop_flow_count !== 7'd0) begin bad++; $display("[TB] FAIL rst_count: got %0d expected 0", pop_flow_count); end
    total++; if (push_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_ready: got %b expected 1", push_ready); end
  endtask

  task automatic test_fifo_order();
    logic [7:0] vals [3];
    vals = '{8'h11, 8'h22, 8'h33};
    idle();
    pop_flow_id = 5'd3;
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1; push_flow_id = 5'd3; push_data = vals[i];
      #1;
      if (i == 0) begin
        total++; if (pop_valid !== 1'b0) begin bad++; $display("[TB] FAIL no_bypass: got %b expected 0", pop_valid); end
      end
      total++; if (push_ready !== 1'b1) begin bad++; $display("[TB] FAIL order_ready: got %b expected 1", push_ready); end
      tick();
    end
    push_valid = 1'b0;
    #1;
    total++; if (pop_valid !== 1'b1) begin bad++; $display("[TB] FAIL order_valid: got %b expected 1", pop_valid); end
    total++; if (pop_flow_count !== 7'd3) begin bad++; $display("[TB] FAIL order_count: got %0d expected 3", pop_flow_count); end
    for (int i = 0; i < 3; i++) begin
      pop = 1'b1;
      #1;
      total++; if (pop_data !== vals[i]) begin bad++; $display("[TB] FAIL order_data%0d: got %h expected %h", i, pop_data, vals[i]); end
      tick();
    end
    pop = 1'b0;
    #1;
    total++; if (pop_valid !== 1'b0) begin bad++; $display("[TB] FAIL order_empty: got %b expected 0", pop_valid); end
  endtask

  task automatic test_interleaved();
    logic [7:0] exp_d;
    idle();
    for (int i = 0; i < 12; i++) begin
      push_valid = 1'b1; push_flow_id = (i % 2 == 1) ? 5'd5 : 5'd0; push_data = 8'($urandom);
      #1;
      total++; if (push_ready !== 1'b1) begin bad++; $display("[TB] FAIL inter_ready: got %b expected 1", push_ready); end
      tick();
    end
    push_valid = 1'b0;
    for (int f = 0; f < 2; f++) begin
      pop_flow_id = (f == 1) ? 5'd5 : 5'd0;
      for (int n = 0; n < 6; n++) begin
        pop = 1'b1;
        #1;
        exp_d = m_head(pop_flow_id);
        total++; if (pop_data !== exp_d) begin bad++; $display("[TB] FAIL inter_data: got %h expected %h", pop_data, exp_d); end
        tick();
      end
    end
    pop = 1'b0;
    #1;
    total++; if (free_count !== 7'd64) begin bad++; $display("[TB] FAIL inter_free: got %0d expected 64", free_count); end
  endtask

  task automatic test_flow_cap();
    idle();
    for (int i = 0; i < MPF; i++) begin
      push_valid = 1'b1; push_flow_id = 5'd2; push_data = 8'(8'h40 + i);
      #1;
      tick();
    end
    #1;
    total++; if (push_ready !== 1'b0) begin bad++; $display("[TB] FAIL cap_full: got %b expected 0", push_ready); end
    push_flow_id = 5'd4;
    #1;
    total++; if (push_ready !== 1'b1) begin bad++; $display("[TB] FAIL cap_other: got %b expected 1", push_ready); end
    push_valid = 1'b0;
  endtask

  task automatic test_pool_full();
    logic [7:0] exp_d;
    idle();
    for (int f = 0; f < 8; f++) begin
      if (f != 2) begin
        for (int j = 0; j < MPF; j++) begin
          push_valid = 1'b1; push_flow_id = 5'(f); push_data = 8'(f * 16 + j);
          #1;
          tick();
        end
      end
    end
    push_valid = 1'b1; push_flow_id = 5'd8;
    #1;
    total++; if (free_count !== 7'd0) begin bad++; $display("[TB] FAIL full_free: got %0d expected 0", free_count); end
    total++; if (push_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_ready: got %b expected 0", push_ready); end
    push_valid = 1'b0;
    pop_flow_id = 5'd1; pop = 1'b1; reinsert_valid = 1'b1; reinsert_data = 8'h7F;
    #1;
    total++; if (pop_data !== 8'h10) begin bad++; $display("[TB] FAIL full_head: got %h expected 10", pop_data); end
    tick();
    pop = 1'b0; reinsert_valid = 1'b0;
    #1;
    total++; if (free_count !== 7'd0) begin bad++; $display("[TB] FAIL reuse_free: got %0d expected 0", free_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reuse_ovf: got %b expected 0", overflow); end
    total++; if (pop_flow_count !== 7'd8) begin bad++; $display("[TB] FAIL reuse_count: got %0d expected 8", pop_flow_count); end
    reinsert_valid = 1'b1; reinsert_data = 8'h55;
    #1;
    tick();
    reinsert_valid = 1'b0;
    #1;
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL drop_ovf: got %b expected 1", overflow); end
    total++; if (pop_flow_count !== 7'd8) begin bad++; $display("[TB] FAIL drop_count: got %0d expected 8", pop_flow_count); end
    for (int f = 0; f < 8; f++) begin
      for (int j = 0; j < MPF; j++) begin
        pop_flow_id = 5'(f); pop = 1'b1;
        #1;
        exp_d = m_head(pop_flow_id);
        total++; if (pop_data !== exp_d) begin bad++; $display("[TB] FAIL drain_f%0d: got %h expected %h", f, pop_data, exp_d); end
        tick();
      end
    end
    pop = 1'b0;
    #1;
    total++; if (free_count !== 7'd64) begin bad++; $display("[TB] FAIL drain_free: got %0d expected 64", free_count); end
  endtask

  task automatic test_pop_reinsert();
    idle();
    reset_pulse();
    push_valid = 1'b1; push_flow_id = 5'd6; push_data = 8'hAA;
    #1;
    tick();
    push_flow_id = 5'd7; push_data = 8'hCC;
    pop_flow_id = 5'd6; pop = 1'b1; reinsert_valid = 1'b1; reinsert_data = 8'hBB;
    #1;
    total++; if (push_ready !== 1'b0) begin bad++; $display("[TB] FAIL reins_ready: got %b expected 0", push_ready); end
    total++; if (pop_data !== 8'hAA) begin bad++; $display("[TB] FAIL reins_old: got %h expected aa", pop_data); end
    tick();
    idle();
    pop_flow_id = 5'd6;
    #1;
    total++; if (pop_flow_count !== 7'd1) begin bad++; $display("[TB] FAIL reins_count: got %0d expected 1", pop_flow_count); end
    total++; if (pop_data !== 8'hBB) begin bad++; $display("[TB] FAIL reins_new: got %h expected bb", pop_data); end
    pop_flow_id = 5'd7;
    #1;
    total++; if (pop_flow_count !== 7'd0) begin bad++; $display("[TB] FAIL reins_push7: got %0d expected 0", pop_flow_count); end
    pop_flow_id = 5'd6; pop = 1'b1;
    #1;
    tick();
    pop = 1'b0;
  endtask

  function automatic logic [4:0] pick_id();
    int r = $urandom_range(0, 9);
    return (r < 8) ? 5'(r) : 5'(16 + $urandom_range(0, 15));
  endfunction

  task automatic test_random();
    logic       e_valid, e_ready;
    logic [7:0] e_data;
    logic [6:0] e_cnt, e_free;
    int         pp, qp, ph;
    for (int c = 0; c < 800; c++) begin
      ph = c / 200;
      pp = (ph == 1) ? 25 : 75;
      qp = (ph == 1) ? 80 : 35;
      push_valid     = ($urandom_range(0, 99) < pp);
      push_flow_id   = pick_id();
      push_data      = 8'($urandom);
      pop_flow_id    = pick_id();
      pop            = ($urandom_range(0, 99) < qp);
      reinsert_valid = ($urandom_range(0, 99) < 10);
      reinsert_data  = 8'($urandom);
      #1;
      e_valid = (m_count(pop_flow_id) != 0);
      e_data  = m_head(pop_flow_id);
      e_cnt   = 7'(m_count(pop_flow_id));
      e_free  = 7'(TD - m_total());
      e_ready = m_ready();
      total++; if (pop_valid !== e_valid) begin bad++; $display("[TB] FAIL rnd_valid c%0d: got %b expected %b", c, pop_valid, e_valid); end
      total++; if (pop_data !== e_data) begin bad++; $display("[TB] FAIL rnd_data c%0d: got %h expected %h", c, pop_data, e_data); end
      total++; if (pop_flow_count !== e_cnt) begin bad++; $display("[TB] FAIL rnd_count c%0d: got %0d expected %0d", c, pop_flow_count, e_cnt); end
      total++; if (free_count !== e_free) begin bad++; $display("[TB] FAIL rnd_free c%0d: got %0d expected %0d", c, free_count, e_free); end
      total++; if (push_ready !== e_ready) begin bad++; $display("[TB] FAIL rnd_ready c%0d: got %b expected %b", c, push_ready, e_ready); end
      total++; if (overflow !== m_ovf) begin bad++; $display("[TB] FAIL rnd_ovf c%0d: got %b expected %b", c, overflow, m_ovf); end
      tick();
    end
    idle();
  endtask

  task automatic test_async_reset();
    idle();
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1; push_flow_id = 5'd9; push_data = 8'(8'hC0 + i);
      #1;
      tick();
    end
    push_valid = 1'b0;
    pop_flow_id = 5'd20; reinsert_valid = 1'b1; reinsert_data = 8'h99;
    #1;
    tick();
    reinsert_valid = 1'b0; pop_flow_id = 5'd9; push_flow_id = 5'd9;
    #1;
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL oor_ovf: got %b expected 1", overflow); end
    total++; if (pop_flow_count !== 7'd3) begin bad++; $display("[TB] FAIL pre_rst_count: got %0d expected 3", pop_flow_count); end
    #1;
    reset = 1'b0;
    #1;
    total++; if (pop_valid !== 1'b0) begin bad++; $display("[TB] FAIL arst_valid: got %b expected 0", pop_valid); end
    total++; if (pop_data !== 8'h00) begin bad++; $display("[TB] FAIL arst_data: got %h expected 00", pop_data); end
    total++; if (pop_flow_count !== 7'd0) begin bad++; $display("[TB] FAIL arst_count: got %0d expected 0", pop_flow_count); end
    total++; if (free_count !== 7'd64) begin bad++; $display("[TB] FAIL arst_free: got %0d expected 64", free_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL arst_ovf: got %b expected 0", overflow); end
    total++; if (push_ready !== 1'b1) begin bad++; $display("[TB] FAIL arst_ready: got %b expected 1", push_ready); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_interleaved();
    test_flow_cap();
    test_pool_full();
    test_pop_reinsert();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
